// File: rtl/gshare_btb_predictor_if.sv
// rtl/gshare_btb_predictor_if.sv - fetch/predict/train bus of the gshare+BTB predictor
interface gshare_btb_predictor_if #(
    parameter int GHR_BITS = 8
);
    logic                fetch_valid;
    logic [31:0]         fetch_pc;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic                pred_hit;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                upd_mispredict;
    logic                ready;
    logic [31:0]         branch_cnt;
    logic [31:0]         mispred_cnt;

    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target, pred_hit, pred_ghr,
        input  ready, branch_cnt, mispred_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target, pred_hit, pred_ghr,
        output ready, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/gshare_btb_predictor.sv
// rtl/gshare_btb_predictor.sv - gshare direction predictor with direct-mapped BTB and perf counters
module gshare_btb_predictor #(
    parameter int GHR_BITS    = 8,
    parameter int BHT_ENTRIES = 256,
    parameter int CNT_BITS    = 2,
    parameter int BTB_ENTRIES = 32,
    parameter int TAG_BITS    = 12
) (
    input logic                   clk,
    input logic                   reset_n,
    gshare_btb_predictor_if.slave bus
);
    localparam int IDX   = $clog2(BHT_ENTRIES);
    localparam int BI    = $clog2(BTB_ENTRIES);
    localparam int SWEEP = (BHT_ENTRIES > BTB_ENTRIES) ? BHT_ENTRIES : BTB_ENTRIES;
    localparam int PTR_W = $clog2(SWEEP);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic                init_en;
    logic                active;
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         branch_q;
    logic [31:0]         mispred_q;

    logic [CNT_BITS-1:0] cnt_tbl    [BHT_ENTRIES];
    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]         btb_target [BTB_ENTRIES];

    logic [IDX-1:0]      fetch_bidx;
    logic [IDX-1:0]      upd_bidx;
    logic [BI-1:0]       fetch_ent;
    logic [BI-1:0]       upd_ent;
    logic [TAG_BITS-1:0] fetch_tag;
    logic [TAG_BITS-1:0] upd_tag;
    logic                hit;
    logic                taken;
    logic                upd_en;
    logic                recover;
    logic                unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (init_en) ptr <= ptr + PTR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && ptr == PTR_W'(SWEEP - 1)) state_nxt = S_READY;
    end

    always_comb begin
        init_en = (state == S_INIT);
        active  = (state == S_READY);
    end

    assign fetch_bidx  = bus.fetch_pc[IDX+1:2] ^ IDX'(ghr);
    assign upd_bidx    = bus.upd_pc[IDX+1:2] ^ IDX'(bus.upd_ghr);
    assign fetch_ent   = bus.fetch_pc[BI+1:2];
    assign upd_ent     = bus.upd_pc[BI+1:2];
    assign fetch_tag   = bus.fetch_pc[BI+2 +: TAG_BITS];
    assign upd_tag     = bus.upd_pc[BI+2 +: TAG_BITS];
    assign unused_bits = ^{bus.fetch_pc, bus.upd_pc, bus.upd_ghr};

    // Prediction reads the arrays before this edge's training write lands
    always_comb begin
        hit             = 1'b0;
        taken           = 1'b0;
        bus.pred_target = '0;
        bus.pred_ghr    = '0;
        if (active) begin
            hit          = btb_valid[fetch_ent] && (btb_tag[fetch_ent] == fetch_tag);
            taken        = hit && cnt_tbl[fetch_bidx][CNT_BITS-1];
            bus.pred_ghr = ghr;
            if (hit) bus.pred_target = btb_target[fetch_ent];
        end
    end

    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = taken;
    assign bus.ready       = active;
    assign bus.branch_cnt  = branch_q;
    assign bus.mispred_cnt = mispred_q;

    assign upd_en  = active && bus.upd_valid;
    assign recover = upd_en && bus.upd_mispredict;

    // A mispredict restore overrides any speculative shift in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr       <= '0;
            branch_q  <= '0;
            mispred_q <= '0;
        end else begin
            if (recover) begin
                ghr <= {bus.upd_ghr[GHR_BITS-2:0], bus.upd_taken};
            end else if (active && bus.fetch_valid && hit) begin
                ghr <= {ghr[GHR_BITS-2:0], taken};
            end
            if (upd_en && branch_q != '1) branch_q <= branch_q + 32'd1;
            if (recover && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
        end
    end

    // Tables are cleared by the sweep rather than by reset
    always_ff @(posedge clk) begin
        if (init_en) begin
            if (32'(ptr) < BHT_ENTRIES) cnt_tbl[ptr[IDX-1:0]] <= CNT_INIT;
            if (32'(ptr) < BTB_ENTRIES) btb_valid[ptr[BI-1:0]] <= 1'b0;
        end else if (upd_en) begin
            if (bus.upd_taken) begin
                if (cnt_tbl[upd_bidx] != CNT_MAX) cnt_tbl[upd_bidx] <= cnt_tbl[upd_bidx] + CNT_BITS'(1);
                btb_valid[upd_ent]  <= 1'b1;
                btb_tag[upd_ent]    <= upd_tag;
                btb_target[upd_ent] <= bus.upd_target;
            end else if (cnt_tbl[upd_bidx] != '0) begin
                cnt_tbl[upd_bidx] <= cnt_tbl[upd_bidx] - CNT_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb/tb_gshare_btb_predictor.sv - model-checked directed bench for gshare_btb_predictor
module tb_gshare_btb_predictor;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    gshare_btb_predictor_if #(.GHR_BITS(8)) bus ();

    gshare_btb_predictor #(
        .GHR_BITS(8), .BHT_ENTRIES(256), .CNT_BITS(2), .BTB_ENTRIES(32), .TAG_BITS(12)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          m_cnt [256];
    bit          m_bv  [32];
    int          m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_ghr;
    int          m_init;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void predict(input logic [31:0] pc, output bit hit, output bit tk,
                                    output logic [31:0] tgt);
        int e;
        int t;
        int b;
        e   = int'((pc >> 2) % 32);
        t   = int'((pc >> 7) % 4096);
        b   = int'((pc >> 2) % 256) ^ m_ghr;
        hit = m_bv[e] && (m_tag[e] == t);
        tk  = hit && (m_cnt[b] >= 2);
        tgt = hit ? m_tgt[e] : 32'd0;
    endfunction

    // Reference model: advances on each clock edge from the same inputs the DUT sees
    initial forever begin
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        int          b;
        int          e;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_init = 0;
            m_ghr  = 0;
            m_br   = 0;
            m_mis  = 0;
            foreach (m_cnt[i]) m_cnt[i] = 1;
            foreach (m_bv[i]) m_bv[i] = 0;
        end else if (m_init < 256) begin
            m_init++;
        end else begin
            predict(bus.fetch_pc, hit, tk, tgt);
            if (bus.upd_valid) begin
                b = int'((bus.upd_pc >> 2) % 256) ^ int'(bus.upd_ghr);
                e = int'((bus.upd_pc >> 2) % 32);
                if (bus.upd_taken) begin
                    m_cnt[b] = (m_cnt[b] == 3) ? 3 : m_cnt[b] + 1;
                    m_bv[e]  = 1;
                    m_tag[e] = int'((bus.upd_pc >> 7) % 4096);
                    m_tgt[e] = bus.upd_target;
                end else begin
                    m_cnt[b] = (m_cnt[b] == 0) ? 0 : m_cnt[b] - 1;
                end
                if (m_br != 32'hFFFF_FFFF) m_br++;
                if (bus.upd_mispredict && m_mis != 32'hFFFF_FFFF) m_mis++;
            end
            if (bus.upd_valid && bus.upd_mispredict)
                m_ghr = ((int'(bus.upd_ghr) << 1) | int'(bus.upd_taken)) % 256;
            else if (bus.fetch_valid && hit)
                m_ghr = ((m_ghr << 1) | int'(tk)) % 256;
        end
    end

    initial forever begin
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        @(negedge clk);
        hit = 0;
        tk  = 0;
        tgt = 0;
        if (m_init == 256) predict(bus.fetch_pc, hit, tk, tgt);
        chk("ready", bus.ready, m_init == 256);
        chk("pred_hit", bus.pred_hit, hit);
        chk("pred_taken", bus.pred_taken, tk);
        chk("pred_target", bus.pred_target, tgt);
        chk("pred_ghr", bus.pred_ghr, (m_init == 256) ? 32'(m_ghr) : 32'd0);
        chk("branch_cnt", bus.branch_cnt, m_br);
        chk("mispred_cnt", bus.mispred_cnt, m_mis);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid    = 0;
        bus.upd_valid      = 0;
        bus.upd_mispredict = 0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [7:0] g, input bit tk,
                           input logic [31:0] tgt, input bit mis);
        bus.upd_valid      = 1;
        bus.upd_pc         = pc;
        bus.upd_ghr        = g;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mis;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ready && n < 600);
    endtask

    initial begin
        int         n;
        logic [7:0] gs [3];
        gs = '{8'h00, 8'h01, 8'h03};
        bus.fetch_pc = 0;
        idle();
        set_upd(32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
        idle();
        repeat (3) tick();

        // Inputs busy during the sweep must be ignored
        bus.fetch_valid = 1;
        bus.fetch_pc    = 32'h100;
        set_upd(32'h100, 8'h00, 1'b1, 32'h80, 1'b1);
        reset_n = 1;
        wait_ready(n);
        idle();
        chk("init_cycles", n, 256);
        chk("init_branch_cnt", bus.branch_cnt, 0);

        set_upd(32'h100, 8'h00, 1'b1, 32'h80, 1'b0);
        repeat (4) tick();
        idle();
        bus.fetch_pc = 32'h100;
        #1;
        chk("t2_hit", bus.pred_hit, 1);
        chk("t2_target", bus.pred_target, 32'h80);
        chk("t2_taken", bus.pred_taken, 1);

        set_upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b0);
        repeat (2) tick();
        idle();
        #1;
        chk("t3_taken", bus.pred_taken, 0);
        chk("t3_hit", bus.pred_hit, 1);

        for (int k = 0; k < 3; k++) begin
            set_upd(32'h100, gs[k], 1'b1, 32'h80, 1'b0);
            repeat (2) tick();
        end
        idle();
        bus.fetch_pc    = 32'h100;
        bus.fetch_valid = 1;
        #1;
        chk("spec_ghr0", bus.pred_ghr, 8'h00);
        chk("spec_taken0", bus.pred_taken, 1);
        tick();
        chk("spec_ghr1", bus.pred_ghr, 8'h01);
        tick();
        set_upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b1);
        #1;
        chk("spec_ghr3", bus.pred_ghr, 8'h03);
        chk("spec_taken3", bus.pred_taken, 1);
        tick();
        idle();
        #1;
        chk("ghr_recover", bus.pred_ghr, 8'h00);

        bus.fetch_pc = 32'h204;
        set_upd(32'h204, 8'h00, 1'b1, 32'h300, 1'b0);
        #1;
        chk("rdw_hit_old", bus.pred_hit, 0);
        tick();
        idle();
        #1;
        chk("rdw_hit_new", bus.pred_hit, 1);
        chk("rdw_target", bus.pred_target, 32'h300);
        bus.fetch_pc = 32'h1100;
        #1;
        chk("btb_alias", bus.pred_hit, 0);

        tick();
        force dut.mispred_q = 32'hFFFF_FFFE;
        m_mis = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_q;
        set_upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b1);
        repeat (2) tick();
        idle();
        #1;
        chk("mispred_sat", bus.mispred_cnt, 32'hFFFF_FFFF);
        chk("branch_total", bus.branch_cnt, 16);

        reset_n = 0;
        tick();
        reset_n = 1;
        repeat (100) tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        wait_ready(n);
        chk("reinit_cycles", n, 256);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
